// File: rtl/conway_board_serializer_if.sv
// Row-stream handshake between the board serializer and its sink.
interface conway_board_serializer_if #(
    parameter int ROWS = 8,
    parameter int COLS = 8
);
    localparam int RW = $clog2(ROWS);

    logic [COLS-1:0] out_data;
    logic [RW-1:0]   out_row;
    logic            out_last;
    logic            out_valid;
    logic            out_ready;

    modport master (
        output out_data,
        output out_row,
        output out_last,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_row,
        input  out_last,
        input  out_valid,
        output out_ready
    );
endinterface

// File: rtl/conway_board_serializer.sv
// Snapshots the conway board on capture and streams it out one row per beat,
// reporting the frame's live-cell population when the last row is accepted.
module conway_board_serializer #(
    parameter int ROWS = 8,
    parameter int COLS = 8
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [ROWS*COLS-1:0]               board_q,
    input  logic                               capture,
    input  logic                               clr_overrun,
    conway_board_serializer_if.master          out_if,
    output logic                               busy,
    output logic [$clog2(ROWS*COLS+1)-1:0]     live_count,
    output logic                               count_valid,
    output logic                               overrun
);
    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(ROWS*COLS+1);

    typedef enum logic {IDLE, SEND} state_t;

    state_t          state_q, state_d;
    logic [RW-1:0]   row_q, row_d;
    logic [COLS-1:0] data_q, data_d;
    logic            last_q, last_d;
    logic            valid_q, valid_d;
    logic            busy_q, busy_d;
    logic [CW-1:0]   acc_q, acc_d;
    logic [CW-1:0]   live_q, live_d;
    logic            cv_q, cv_d;
    logic            ovr_q, ovr_d;
    logic            snap_we;
    logic [COLS-1:0] snap_q [ROWS];

    function automatic logic [CW-1:0] popcnt(input logic [COLS-1:0] v);
        logic [CW-1:0] n;
        n = '0;
        for (int i = 0; i < COLS; i++) n = n + CW'(v[i]);
        return n;
    endfunction

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        data_d  = data_q;
        last_d  = last_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        acc_d   = acc_q;
        live_d  = live_q;
        cv_d    = 1'b0;
        ovr_d   = ovr_q;
        snap_we = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (capture) begin
                    snap_we = 1'b1;
                    state_d = SEND;
                    row_d   = '0;
                    acc_d   = '0;
                    data_d  = board_q[COLS-1:0];
                    last_d  = 1'b0;
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                end
            end
            SEND: begin
                if (out_if.out_ready) begin
                    acc_d = acc_q + popcnt(data_q);
                    if (last_q) begin
                        state_d = IDLE;
                        valid_d = 1'b0;
                        busy_d  = 1'b0;
                        last_d  = 1'b0;
                        live_d  = acc_q + popcnt(data_q);
                        cv_d    = 1'b1;
                    end else begin
                        row_d  = row_q + 1'b1;
                        data_d = snap_q[row_d];
                        last_d = (row_d == RW'(ROWS-1));
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        // A capture that cannot be honoured takes priority over the clear.
        if (clr_overrun) ovr_d = 1'b0;
        if (capture && state_q == SEND) ovr_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            row_q   <= '0;
            data_q  <= '0;
            last_q  <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            acc_q   <= '0;
            live_q  <= '0;
            cv_q    <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            data_q  <= data_d;
            last_q  <= last_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            acc_q   <= acc_d;
            live_q  <= live_d;
            cv_q    <= cv_d;
            ovr_q   <= ovr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (snap_we) begin
            for (int r = 0; r < ROWS; r++) snap_q[r] <= board_q[r*COLS +: COLS];
        end
    end

    assign out_if.out_data  = data_q;
    assign out_if.out_row   = row_q;
    assign out_if.out_last  = last_q;
    assign out_if.out_valid = valid_q;
    assign busy             = busy_q;
    assign live_count       = live_q;
    assign count_valid      = cv_q;
    assign overrun          = ovr_q;
endmodule
